// File: rtl/atomrvcore_pkg.sv
// Shared types for the atomRVCORE pipeline control logic.
package atomrvcore_pkg;

    // Hazard controller sequencing states; encoding 3 is unused.
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // ALU operand source select.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

endpackage

// File: rtl/atomrvcore_sat_counter.sv
// Event counter that sticks at all-ones; cleared only by reset.
module atomrvcore_sat_counter #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 inc_i,
    output logic [CNT_WIDTH-1:0] cnt_o
);

    // Count qualifying events, holding once the counter is full.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

endmodule

// File: rtl/atomrvcore_hazard_ctrl.sv
// Boot sequencing, hazard detection, flush/stall and operand forwarding for the
// fetch/decode/ALU/data-memory pipeline.
module atomrvcore_hazard_ctrl
    import atomrvcore_pkg::*;
#(
    parameter int unsigned REG_ADRESS_WIDTH = 5,
    parameter int unsigned BOOT_CYCLES      = 4,
    parameter int unsigned FLUSH_CYCLES     = 2,
    parameter int unsigned CNT_WIDTH        = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [REG_ADRESS_WIDTH-1:0] id_rs1_i,
    input  logic [REG_ADRESS_WIDTH-1:0] id_rs2_i,
    input  logic                        id_rs1_use_i,
    input  logic                        id_rs2_use_i,
    input  logic [REG_ADRESS_WIDTH-1:0] ex_rd_i,
    input  logic                        ex_rwr_en_i,
    input  logic                        ex_dr_en_i,
    input  logic [REG_ADRESS_WIDTH-1:0] mem_rd_i,
    input  logic                        mem_rwr_en_i,
    input  logic                        ex_br_taken_i,
    output logic                        PCrst_o,
    output logic                        stall_if_o,
    output logic                        stall_id_o,
    output logic                        flush_id_o,
    output logic                        flush_ex_o,
    output logic [1:0]                  fwd_a_o,
    output logic [1:0]                  fwd_b_o,
    output logic [1:0]                  state_o,
    output logic [CNT_WIDTH-1:0]        stall_cnt_o,
    output logic [CNT_WIDTH-1:0]        flush_cnt_o
);

    localparam int unsigned BOOT_W  = $clog2(BOOT_CYCLES) + 1;
    localparam int unsigned FLUSH_W = $clog2(FLUSH_CYCLES) + 1;
    localparam logic [BOOT_W-1:0]  BOOT_LAST  = BOOT_W'(BOOT_CYCLES - 1);
    localparam logic [FLUSH_W-1:0] FLUSH_INIT = FLUSH_W'(FLUSH_CYCLES - 1);

    state_t               state;
    logic [BOOT_W-1:0]    boot_cnt;
    logic [FLUSH_W-1:0]   flush_left;
    logic                 pc_rst;

    logic                 load_use;
    logic                 stall;
    logic                 flush_id;
    logic                 flush_ex;
    fwd_sel_t             fwd_a;
    fwd_sel_t             fwd_b;
    logic                 stall_inc;
    logic                 flush_inc;

    // Load in ALU stage whose destination is read by decode; x0 never matches.
    assign load_use = ex_dr_en_i && ex_rwr_en_i && (ex_rd_i != '0) &&
                      ((id_rs1_use_i && (id_rs1_i == ex_rd_i)) ||
                       (id_rs2_use_i && (id_rs2_i == ex_rd_i)));

    // Zero-latency stall/flush/forward decisions from current state and inputs.
    always_comb begin
        stall     = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        fwd_a     = FWD_RF;
        fwd_b     = FWD_RF;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        case (state)
            RUN: begin
                // A taken branch squashes the hazard-carrying instruction anyway.
                if (ex_br_taken_i) begin
                    flush_id  = 1'b1;
                    flush_ex  = 1'b1;
                    flush_inc = 1'b1;
                end else if (load_use) begin
                    stall     = 1'b1;
                    flush_ex  = 1'b1;
                    stall_inc = 1'b1;
                end
                if (id_rs1_use_i && (id_rs1_i != '0) && ex_rwr_en_i && !ex_dr_en_i &&
                    (id_rs1_i == ex_rd_i)) begin
                    fwd_a = FWD_EX;
                end else if (id_rs1_use_i && (id_rs1_i != '0) && mem_rwr_en_i &&
                             (id_rs1_i == mem_rd_i)) begin
                    fwd_a = FWD_MEM;
                end
                if (id_rs2_use_i && (id_rs2_i != '0) && ex_rwr_en_i && !ex_dr_en_i &&
                    (id_rs2_i == ex_rd_i)) begin
                    fwd_b = FWD_EX;
                end else if (id_rs2_use_i && (id_rs2_i != '0) && mem_rwr_en_i &&
                             (id_rs2_i == mem_rd_i)) begin
                    fwd_b = FWD_MEM;
                end
            end
            default: begin
                // BOOT, FLUSH and the unused encoding keep the pipe squashed.
                flush_id = 1'b1;
                flush_ex = 1'b1;
            end
        endcase
    end

    // Sequencing FSM: boot window, run, and multi-cycle branch flush.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= BOOT;
            boot_cnt   <= '0;
            flush_left <= '0;
            pc_rst     <= 1'b1;
        end else begin
            case (state)
                BOOT: begin
                    if (boot_cnt == BOOT_LAST) begin
                        state  <= RUN;
                        pc_rst <= 1'b0;
                    end else begin
                        boot_cnt <= boot_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (ex_br_taken_i && (FLUSH_CYCLES > 1)) begin
                        state      <= FLUSH;
                        flush_left <= FLUSH_INIT;
                    end
                end
                FLUSH: begin
                    if (flush_left <= FLUSH_W'(1)) begin
                        state <= RUN;
                    end else begin
                        flush_left <= flush_left - 1'b1;
                    end
                end
                default: begin
                    state    <= BOOT;
                    boot_cnt <= '0;
                    pc_rst   <= 1'b1;
                end
            endcase
        end
    end

    assign PCrst_o    = pc_rst;
    assign stall_if_o = stall;
    assign stall_id_o = stall;
    assign flush_id_o = flush_id;
    assign flush_ex_o = flush_ex;
    assign fwd_a_o    = fwd_a;
    assign fwd_b_o    = fwd_b;
    assign state_o    = state;

    atomrvcore_sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (stall_inc),
        .cnt_o (stall_cnt_o)
    );

    atomrvcore_sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (flush_inc),
        .cnt_o (flush_cnt_o)
    );

endmodule

// File: tb/tb_atomrvcore_hazard_ctrl.sv
// Scoreboard bench for the hazard controller: stimulus queues expected outputs,
// a monitor pops and compares them on the falling edge or on demand.
module tb_atomrvcore_hazard_ctrl;

    typedef struct packed {
        logic        pcrst;
        logic        stall_if;
        logic        stall_id;
        logic        flush_id;
        logic        flush_ex;
        logic [1:0]  fwd_a;
        logic [1:0]  fwd_b;
        logic [1:0]  state;
        logic [15:0] scnt;
        logic [15:0] fcnt;
    } obs_t;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd;
    logic        id_rs1_use, id_rs2_use, ex_rwr_en, ex_dr_en, mem_rwr_en, ex_br_taken;
    logic        pcrst, stall_if, stall_id, flush_id, flush_ex;
    logic [1:0]  fwd_a, fwd_b, state;
    logic [15:0] stall_cnt, flush_cnt;
    logic        chk_now;

    obs_t  exp_q[$];
    string name_q[$];
    int    n_total = 0;
    int    n_pass  = 0;

    atomrvcore_hazard_ctrl #(
        .REG_ADRESS_WIDTH (5),
        .BOOT_CYCLES      (4),
        .FLUSH_CYCLES     (2),
        .CNT_WIDTH        (16)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .id_rs1_use_i  (id_rs1_use),
        .id_rs2_use_i  (id_rs2_use),
        .ex_rd_i       (ex_rd),
        .ex_rwr_en_i   (ex_rwr_en),
        .ex_dr_en_i    (ex_dr_en),
        .mem_rd_i      (mem_rd),
        .mem_rwr_en_i  (mem_rwr_en),
        .ex_br_taken_i (ex_br_taken),
        .PCrst_o       (pcrst),
        .stall_if_o    (stall_if),
        .stall_id_o    (stall_id),
        .flush_id_o    (flush_id),
        .flush_ex_o    (flush_ex),
        .fwd_a_o       (fwd_a),
        .fwd_b_o       (fwd_b),
        .state_o       (state),
        .stall_cnt_o   (stall_cnt),
        .flush_cnt_o   (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected-value builder; PCrst is high exactly in BOOT.
    function automatic obs_t mk(input logic [1:0] st, input logic stl, input logic fid,
                                input logic fex, input logic [1:0] fa, input logic [1:0] fb,
                                input int sc, input int fc);
        obs_t r;
        r.pcrst    = (st == 2'd0);
        r.stall_if = stl;
        r.stall_id = stl;
        r.flush_id = fid;
        r.flush_ex = fex;
        r.fwd_a    = fa;
        r.fwd_b    = fb;
        r.state    = st;
        r.scnt     = 16'(sc);
        r.fcnt     = 16'(fc);
        return r;
    endfunction

    task automatic push(input obs_t e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Queue an expectation for this cycle, then advance to just after the next edge.
    task automatic expect_cycle(input obs_t e, input string nm);
        push(e, nm);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0; mem_rd = '0;
        id_rs1_use = 0; id_rs2_use = 0; ex_rwr_en = 0; ex_dr_en = 0;
        mem_rwr_en = 0; ex_br_taken = 0;
    endtask

    task automatic set_load_use_rs2_5();
        ex_rd = 5'd5; ex_dr_en = 1; ex_rwr_en = 1; id_rs2 = 5'd5; id_rs2_use = 1;
    endtask

    // Monitor: compare DUT outputs against the oldest pending expectation.
    always begin
        obs_t  got, e;
        string nm;
        @(negedge clk or posedge chk_now);
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            got = '{pcrst, stall_if, stall_id, flush_id, flush_ex, fwd_a, fwd_b, state,
                    stall_cnt, flush_cnt};
            n_total++;
            if (got === e) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got pcrst=%0b stall=%0b/%0b flush=%0b/%0b fwd=%0d/%0d state=%0d scnt=%0d fcnt=%0d, want pcrst=%0b stall=%0b/%0b flush=%0b/%0b fwd=%0d/%0d state=%0d scnt=%0d fcnt=%0d",
                         nm, got.pcrst, got.stall_if, got.stall_id, got.flush_id,
                         got.flush_ex, got.fwd_a, got.fwd_b, got.state, got.scnt, got.fcnt,
                         e.pcrst, e.stall_if, e.stall_id, e.flush_id, e.flush_ex, e.fwd_a,
                         e.fwd_b, e.state, e.scnt, e.fcnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, pending=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        chk_now = 0;
        rst = 1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        expect_cycle(mk(2'd0, 0, 1, 1, 2'b00, 2'b00, 0, 0), "reset_values");

        // Boot window: four edges in BOOT after release, RUN after the fourth.
        rst = 0;
        for (int i = 0; i < 4; i++) expect_cycle(mk(2'd0, 0, 1, 1, 0, 0, 0, 0), "boot_hold");
        expect_cycle(mk(2'd1, 0, 0, 0, 0, 0, 0, 0), "boot_to_run");

        // Load-use on rs2, then MEM forwarding once the load has moved on.
        set_load_use_rs2_5();
        expect_cycle(mk(2'd1, 1, 0, 1, 2'b00, 2'b00, 0, 0), "load_use_stall");
        clear_inputs();
        id_rs2 = 5'd5; id_rs2_use = 1; mem_rd = 5'd5; mem_rwr_en = 1;
        expect_cycle(mk(2'd1, 0, 0, 0, 2'b00, 2'b10, 1, 0), "load_use_mem_fwd");

        // EX beats MEM, x0 never forwards.
        clear_inputs();
        ex_rd = 5'd7; mem_rd = 5'd7; ex_rwr_en = 1; mem_rwr_en = 1; id_rs1 = 5'd7; id_rs1_use = 1;
        expect_cycle(mk(2'd1, 0, 0, 0, 2'b01, 2'b00, 1, 0), "fwd_ex_priority");
        id_rs1 = 5'd0;
        expect_cycle(mk(2'd1, 0, 0, 0, 2'b00, 2'b00, 1, 0), "fwd_x0_none");
        ex_rwr_en = 0; id_rs1 = 5'd7; id_rs2 = 5'd7; id_rs2_use = 1;
        expect_cycle(mk(2'd1, 0, 0, 0, 2'b10, 2'b10, 1, 0), "fwd_mem_both");

        // Load to x0 read through rs1=x0 is not a hazard.
        clear_inputs();
        ex_dr_en = 1; ex_rwr_en = 1; id_rs1_use = 1;
        expect_cycle(mk(2'd1, 0, 0, 0, 2'b00, 2'b00, 1, 0), "load_x0_no_stall");

        // Branch: two flush cycles, second branch and hazard in FLUSH ignored.
        clear_inputs();
        ex_br_taken = 1;
        expect_cycle(mk(2'd1, 0, 1, 1, 0, 0, 1, 0), "branch_flush_c0");
        set_load_use_rs2_5();
        expect_cycle(mk(2'd2, 0, 1, 1, 0, 0, 1, 1), "branch_flush_c1");
        clear_inputs();
        expect_cycle(mk(2'd1, 0, 0, 0, 0, 0, 1, 1), "branch_flush_done");

        // Branch and load-use together: flush only, stall count held.
        ex_br_taken = 1;
        set_load_use_rs2_5();
        expect_cycle(mk(2'd1, 0, 1, 1, 2'b00, 2'b00, 1, 1), "branch_beats_load_use");
        clear_inputs();

        // Mid-FLUSH, assert reset between edges; outputs must drop immediately.
        push(mk(2'd2, 0, 1, 1, 0, 0, 1, 2), "second_flush_state");
        @(negedge clk);
        #2;
        rst = 1;
        #1;
        push(mk(2'd0, 0, 1, 1, 0, 0, 0, 0), "async_reset_mid_flush");
        chk_now = 1;
        #1;
        chk_now = 0;
        @(posedge clk);
        #1;
        expect_cycle(mk(2'd0, 0, 1, 1, 0, 0, 0, 0), "reset_held");

        // Boot sequence repeats in full.
        rst = 0;
        for (int i = 0; i < 4; i++) expect_cycle(mk(2'd0, 0, 1, 1, 0, 0, 0, 0), "reboot_hold");
        expect_cycle(mk(2'd1, 0, 0, 0, 0, 0, 0, 0), "reboot_to_run");

        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations never compared, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
